aes128_ecb_iter_dec: RTL and testbench

Iterative AES-128 ECB decryption core: the inverse-cipher counterpart of the team's iterative AES-128 ECB encryption core, using the same AXI-Stream framing. It accepts a 128-bit key followed by one or more 128-bit ciphertext blocks on a slave stream and returns the plaintext blocks on a master stream. It computes one inverse round per clock. The final round key is derived once per key session and reused for every block in that session.

---
 rtl/aes128_ecb_iter_dec_if.sv | 13 +
 rtl/aes128_ecb_iter_dec.sv | 231 +++++++++++++++++++++++
 tb/tb_aes128_ecb_iter_dec.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_ecb_iter_dec_if.sv
// AXI-Stream bundle shared by the slave (key/ciphertext) and master (plaintext) sides.
interface axis_if #(
  parameter int W = 32
);
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tkeep;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/aes128_ecb_iter_dec.sv
// Iterative AES-128 ECB decryption: key beats, then ciphertext blocks in, plaintext blocks out.
// One inverse round per clock; round key 10 is expanded once per key session.
module aes128_ecb_iter_dec #(
  parameter int S_AXIS_WIDTH = 32,
  parameter int M_AXIS_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  axis_if.slave      s_axis,
  axis_if.master     m_axis,
  output logic [6:0] fsm_state
);
  localparam int S_BEATS = 128 / S_AXIS_WIDTH;
  localparam int M_BEATS = 128 / M_AXIS_WIDTH;
  localparam int S_CW = (S_BEATS > 1) ? $clog2(S_BEATS) : 1;
  localparam int M_CW = (M_BEATS > 1) ? $clog2(M_BEATS) : 1;

  typedef enum logic [6:0] {
    ST_KEY_IN        = 7'b0000001,
    ST_KEY_EXPAND    = 7'b0000010,
    ST_CIPHERTEXT_IN = 7'b0000100,
    ST_FIRST_ROUND   = 7'b0001000,
    ST_MIDDLE_ROUND  = 7'b0010000,
    ST_FINAL_ROUND   = 7'b0100000,
    ST_PLAINTEXT_OUT = 7'b1000000
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int b = 0; b < 4; b++) o[8*b +: 8] = sbox(w[8*b +: 8]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Words sit little-endian: w0 = bits [31:0], FIPS byte 0 in [7:0], so RotWord is a byte rotate right.
  function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w3, w2, w1, w0} = k;
    w0 = w0 ^ sub_word({w3[7:0], w3[31:8]}) ^ {24'h0, rc};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w3, w2, w1, w0} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_word({w3[7:0], w3[31:8]}) ^ {24'h0, rc};
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = inv_sbox(s[8*(4*((c-r)&3)+r) +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a3, a2, a1, a0} = s[32*c +: 32];
      o[32*c +: 8]    = gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9);
      o[32*c+8 +: 8]  = gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13);
      o[32*c+16 +: 8] = gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11);
      o[32*c+24 +: 8] = gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14);
    end
    return o;
  endfunction

  state_t            st, st_nxt;
  logic [127:0]      cipher_key, dec_key, work_key, blk;
  logic [3:0]        rnd;
  logic [S_CW-1:0]   in_cnt;
  logic [M_CW-1:0]   out_cnt;
  logic              last_flag;
  logic              s_rdy, m_vld, s_hs, m_hs, in_last, out_last;
  logic [127:0]      in_base, s_shift, next_key, isb;
  logic              unused_tkeep;

  // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
  // the master side holds tdata/tlast stable and keeps tvalid up until that edge.
  assign s_hs     = s_axis.tvalid && s_rdy;
  assign m_hs     = m_vld && m_axis.tready;
  assign in_last  = (in_cnt == S_CW'(S_BEATS - 1));
  assign out_last = (out_cnt == M_CW'(M_BEATS - 1));
  assign in_base  = (st == ST_KEY_IN) ? cipher_key : blk;
  assign s_shift  = (in_base >> S_AXIS_WIDTH) | (128'(s_axis.tdata) << (128 - S_AXIS_WIDTH));
  assign next_key = inv_key_step(work_key, rcon(rnd + 4'd1));
  assign isb      = inv_shift_sub(blk);
  assign unused_tkeep = ^s_axis.tkeep;

  always_comb begin
    st_nxt = st;
    s_rdy  = 1'b0;
    m_vld  = 1'b0;
    case (st)
      ST_KEY_IN: begin
        s_rdy = rst_n;
        if (s_hs && in_last) st_nxt = ST_KEY_EXPAND;
      end
      ST_KEY_EXPAND:    if (rnd == 4'd10) st_nxt = ST_CIPHERTEXT_IN;
      ST_CIPHERTEXT_IN: begin
        s_rdy = rst_n;
        if (s_hs && in_last) st_nxt = ST_FIRST_ROUND;
      end
      ST_FIRST_ROUND:   st_nxt = ST_MIDDLE_ROUND;
      ST_MIDDLE_ROUND:  if (rnd == 4'd1) st_nxt = ST_FINAL_ROUND;
      ST_FINAL_ROUND:   st_nxt = ST_PLAINTEXT_OUT;
      ST_PLAINTEXT_OUT: begin
        m_vld = 1'b1;
        if (m_hs && out_last) st_nxt = last_flag ? ST_KEY_IN : ST_CIPHERTEXT_IN;
      end
      default:          st_nxt = ST_KEY_IN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_KEY_IN;
      cipher_key <= '0;
      dec_key    <= '0;
      work_key   <= '0;
      blk        <= '0;
      rnd        <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      last_flag  <= 1'b0;
    end else begin
      st <= st_nxt;
      case (st)
        ST_KEY_IN: if (s_hs) begin
          cipher_key <= s_shift;
          dec_key    <= s_shift;
          in_cnt     <= in_last ? '0 : in_cnt + 1'b1;
          if (in_last) rnd <= 4'd1;
        end
        ST_KEY_EXPAND: begin
          dec_key <= fwd_key_step(dec_key, rcon(rnd));
          rnd     <= rnd + 4'd1;
        end
        ST_CIPHERTEXT_IN: if (s_hs) begin
          blk    <= s_shift;
          in_cnt <= in_last ? '0 : in_cnt + 1'b1;
          if (in_last) last_flag <= s_axis.tlast;
        end
        ST_FIRST_ROUND: begin
          blk      <= blk ^ dec_key;
          work_key <= dec_key;
          rnd      <= 4'd9;
        end
        ST_MIDDLE_ROUND: begin
          blk      <= inv_mix_columns(isb ^ next_key);
          work_key <= next_key;
          rnd      <= rnd - 4'd1;
        end
        ST_FINAL_ROUND: blk <= isb ^ cipher_key;
        ST_PLAINTEXT_OUT: if (m_hs) begin
          blk     <= blk >> M_AXIS_WIDTH;
          out_cnt <= out_last ? '0 : out_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = m_vld ? blk[M_AXIS_WIDTH-1:0] : '0;
  assign m_axis.tkeep  = m_vld ? '1 : '0;
  assign m_axis.tlast  = m_vld && out_last && last_flag;
  assign fsm_state     = st;
endmodule

// File: tb/tb_aes128_ecb_iter_dec.sv
// Bench for aes128_ecb_iter_dec: FIPS-197 vectors through a 32-bit and a 128-bit instance.
module tb_aes128_ecb_iter_dec;
  localparam logic [127:0] KEY_C1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT_C1  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] PT_C1  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KEY_B  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] CT_B   = 128'h320b6a19978511dcfb09dc021d842539;
  localparam logic [127:0] PT_B   = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [6:0] ST_KEY_IN = 7'h01;
  localparam logic [6:0] ST_CT_IN  = 7'h04;
  localparam logic [6:0] ST_MID    = 7'h10;

  logic        clk, rst_n;
  logic [6:0]  fsm32, fsm128;
  int          tests, fails;
  bit          bp_en;
  logic [32:0]  exp_q[$];
  logic [128:0] exp128_q[$];

  axis_if #(.W(32))  s32 ();
  axis_if #(.W(32))  m32 ();
  axis_if #(.W(128)) s128 ();
  axis_if #(.W(128)) m128 ();

  aes128_ecb_iter_dec #(.S_AXIS_WIDTH(32), .M_AXIS_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .s_axis(s32), .m_axis(m32), .fsm_state(fsm32));
  aes128_ecb_iter_dec #(.S_AXIS_WIDTH(128), .M_AXIS_WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .s_axis(s128), .m_axis(m128), .fsm_state(fsm128));

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input bit wide, input logic [127:0] d, input logic l, output int waited);
    waited = 0;
    if (wide) begin
      s128.tdata = d; s128.tlast = l; s128.tvalid = 1'b1;
    end else begin
      s32.tdata = d[31:0]; s32.tlast = l; s32.tvalid = 1'b1;
    end
    @(negedge clk);
    while (!(wide ? s128.tready : s32.tready) && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    chk("s_ready_timeout", 160'(waited >= 200), 160'd0);
    @(posedge clk); #1;
    s32.tvalid = 1'b0; s32.tlast = 1'b0;
    s128.tvalid = 1'b0; s128.tlast = 1'b0;
  endtask

  task automatic send_key(input bit wide, input logic [127:0] key);
    int w;
    if (wide) send_beat(1'b1, key, 1'b0, w);
    else for (int i = 0; i < 4; i++) send_beat(1'b0, key >> (32 * i), 1'b0, w);
  endtask

  task automatic send_block(input bit wide, input logic [127:0] ct, input logic [3:0] lasts,
                            input logic [127:0] pt, input logic exp_last, input bit push,
                            output int first_wait);
    int w;
    if (wide) begin
      if (push) exp128_q.push_back({exp_last, pt});
      send_beat(1'b1, ct, lasts[0], first_wait);
    end else begin
      if (push)
        for (int i = 0; i < 4; i++) exp_q.push_back({exp_last && (i == 3), pt[32*i +: 32]});
      for (int i = 0; i < 4; i++) begin
        send_beat(1'b0, ct[32*i +: 32], lasts[i], w);
        if (i == 0) first_wait = w;
      end
    end
  endtask

  task automatic drain(input bit wide);
    int n;
    n = 0;
    while ((wide ? exp128_q.size() : exp_q.size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", 160'(n >= 500), 160'd0);
  endtask

  task automatic wait_valid32(output int n);
    n = 0;
    @(negedge clk);
    while (!m32.tvalid && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  // scoreboard for the 32-bit instance, with the hold check on stalled beats
  task automatic mon32();
    logic [32:0] held, e;
    logic        stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 1'b0;
      else begin
        if (stalled) chk("hold32", {m32.tvalid, m32.tlast, m32.tdata}, {1'b1, held});
        if (m32.tvalid && m32.tready) begin
          tests++;
          assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL spurious_beat32: observed %h expected no beat", {m32.tlast, m32.tdata});
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat32", {m32.tkeep, m32.tlast, m32.tdata}, {4'hf, e});
          end
        end
        stalled = m32.tvalid && !m32.tready;
        held = {m32.tlast, m32.tdata};
      end
    end
  endtask

  task automatic mon128();
    logic [128:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && m128.tvalid && m128.tready) begin
        tests++;
        assert (exp128_q.size() > 0) else begin
          fails++;
          $error("FAIL spurious_beat128: observed %h expected no beat", {m128.tlast, m128.tdata});
        end
        if (exp128_q.size() > 0) begin
          e = exp128_q.pop_front();
          chk("beat128", {m128.tkeep, m128.tlast, m128.tdata}, {16'hffff, e});
        end
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk); #1;
      m32.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    int w, n;
    tests = 0; fails = 0; bp_en = 1'b0; rst_n = 1'b0;
    s32.tvalid = 1'b0; s32.tdata = '0; s32.tlast = 1'b0; s32.tkeep = '1;
    s128.tvalid = 1'b0; s128.tdata = '0; s128.tlast = 1'b0; s128.tkeep = '1;
    m32.tready = 1'b1; m128.tready = 1'b1;
    fork
      mon32();
      mon128();
      ready_gen();
    join_none

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out32", {fsm32, s32.tready, m32.tvalid, m32.tkeep, m32.tlast, m32.tdata},
        {ST_KEY_IN, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0});
    chk("reset_out128", {fsm128, s128.tready, m128.tvalid, m128.tlast, m128.tdata},
        {ST_KEY_IN, 1'b0, 1'b0, 1'b0, 128'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", {s32.tready, s128.tready}, 2'b11);
    @(posedge clk); #1;

    // basic FIPS-197 C.1 vector
    send_key(1'b0, KEY_C1);
    send_block(1'b0, CT_C1, 4'b1000, PT_C1, 1'b1, 1'b1, w);
    chk("key_setup_wait", 160'(w), 160'd10);
    wait_valid32(n);
    chk("first_valid_latency", 160'(n), 160'd11);
    drain(1'b0);
    chk("fsm_after_basic", 160'(fsm32), 160'(ST_KEY_IN));

    // two-block session, stray tlast, back-pressure
    send_key(1'b0, KEY_C1);
    send_block(1'b0, CT_C1, 4'b0000, PT_C1, 1'b0, 1'b1, w);
    chk("rekey_setup_wait", 160'(w), 160'd10);
    drain(1'b0);
    chk("fsm_after_tlast0", 160'(fsm32), 160'(ST_CT_IN));
    send_block(1'b0, CT_C1, 4'b0010, PT_C1, 1'b0, 1'b1, w);
    chk("no_reexpand_wait", 160'(w), 160'd0);
    drain(1'b0);
    chk("fsm_after_stray_tlast", 160'(fsm32), 160'(ST_CT_IN));
    bp_en = 1'b1;
    send_block(1'b0, CT_C1, 4'b1000, PT_C1, 1'b1, 1'b1, w);
    chk("bp_ready_wait", 160'(w), 160'd0);
    drain(1'b0);
    bp_en = 1'b0;
    chk("fsm_after_bp", 160'(fsm32), 160'(ST_KEY_IN));
    send_key(1'b0, KEY_B);
    send_block(1'b0, CT_B, 4'b1000, PT_B, 1'b1, 1'b1, w);
    drain(1'b0);
    chk("fsm_after_appx_b", 160'(fsm32), 160'(ST_KEY_IN));

    // reset during the middle rounds
    @(posedge clk); #1;
    send_key(1'b0, KEY_C1);
    send_block(1'b0, CT_C1, 4'b1000, PT_C1, 1'b1, 1'b0, w);
    repeat (4) @(posedge clk);
    #1;
    chk("fsm_mid_round", 160'(fsm32), 160'(ST_MID));
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {fsm32, s32.tready, m32.tvalid}, {ST_KEY_IN, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_abort", 160'(s32.tready), 160'd1);
    n = 0;
    repeat (20) begin
      if (m32.tvalid) n++;
      @(negedge clk);
    end
    chk("no_valid_after_abort", 160'(n), 160'd0);
    @(posedge clk); #1;
    send_key(1'b0, KEY_C1);
    send_block(1'b0, CT_C1, 4'b1000, PT_C1, 1'b1, 1'b1, w);
    chk("setup_after_abort", 160'(w), 160'd10);
    drain(1'b0);

    // 128-bit instance
    send_key(1'b1, KEY_C1);
    send_block(1'b1, CT_C1, 4'b0001, PT_C1, 1'b1, 1'b1, w);
    chk("key_setup_wait128", 160'(w), 160'd10);
    drain(1'b1);
    chk("fsm_after_128", 160'(fsm128), 160'(ST_KEY_IN));
    send_key(1'b1, KEY_B);
    send_block(1'b1, CT_B, 4'b0001, PT_B, 1'b1, 1'b1, w);
    drain(1'b1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
